call_return_ctrl: RTL and testbench

Sequencer that drives the hardware return-address stack on behalf of the instruction decoder. On CALL it pushes the return address (PC+1) and redirects the program counter to the call target. On RET it pops the stored address and loads it into the program counter. It is the initiator on the stack's CE/nRW/DATA/FULL/EMPTY port and sits between the decoder/PC register and the stack.

---
 rtl/call_return_ctrl.sv | 116 +++++++++++
 tb/tb_call_return_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: pushes PC+1 and jumps on CALL, pops into the PC on RET.
// Optional sticky OVERFLOW/UNDERFLOW flags when CALLRET_ERR_STICKY_EN is defined.
module call_return_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CALL,
    input  logic                  RET,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [ADDR_WIDTH-1:0] TARGET,
    input  logic                  ERR_CLR,
    output logic [ADDR_WIDTH-1:0] STK_DATA_OUT,
    output logic                  STK_nRW,
    output logic                  STK_CE,
    input  logic [ADDR_WIDTH-1:0] STK_DATA_IN,
    input  logic                  STK_FULL,
    input  logic                  STK_EMPTY,
    output logic                  PC_LOAD,
    output logic [ADDR_WIDTH-1:0] PC_NEXT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    typedef enum logic [2:0] {IDLE, PUSH, JUMP, POP, WAIT, RLOAD} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] target_q;

`ifndef CALLRET_ERR_STICKY_EN
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
`endif

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            target_q     <= '0;
            STK_DATA_OUT <= '0;
            STK_nRW      <= 1'b0;
            STK_CE       <= 1'b0;
            PC_LOAD      <= 1'b0;
            PC_NEXT      <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
`ifdef CALLRET_ERR_STICKY_EN
            if (ERR_CLR) begin
                OVERFLOW  <= 1'b0;
                UNDERFLOW <= 1'b0;
            end
`else
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
`endif
            // A new error assigned below overrides the clear above.
            case (state_q)
                IDLE: begin
                    if (CALL) begin
                        if (STK_FULL) begin
                            OVERFLOW <= 1'b1;
                        end else begin
                            target_q     <= TARGET;
                            STK_DATA_OUT <= PC + 1'b1;
                            STK_nRW      <= 1'b1;
                            STK_CE       <= 1'b1;
                            BUSY         <= 1'b1;
                            state_q      <= PUSH;
                        end
                    end else if (RET) begin
                        if (STK_EMPTY) begin
                            UNDERFLOW <= 1'b1;
                        end else begin
                            STK_nRW <= 1'b0;
                            STK_CE  <= 1'b1;
                            BUSY    <= 1'b1;
                            state_q <= POP;
                        end
                    end
                end
                PUSH: begin
                    STK_CE  <= 1'b0;
                    PC_LOAD <= 1'b1;
                    PC_NEXT <= target_q;
                    DONE    <= 1'b1;
                    state_q <= JUMP;
                end
                JUMP, RLOAD: begin
                    PC_LOAD <= 1'b0;
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    state_q <= IDLE;
                end
                POP: begin
                    STK_CE  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Stack read data became valid on the previous (pop) edge.
                    PC_NEXT <= STK_DATA_IN;
                    PC_LOAD <= 1'b1;
                    DONE    <= 1'b1;
                    state_q <= RLOAD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Self-checking bench for call_return_ctrl: cycle vector table through a scoreboard
// queue, plus latency-checked CALL/RET sequences against a behavioural stack.
module tb_call_return_ctrl;

`ifdef CALLRET_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1, CALL = 1'b0, RET = 1'b0, ERR_CLR = 1'b0;
    logic [7:0] PC = '0, TARGET = '0;
    logic [7:0] STK_DATA_OUT, STK_DATA_IN, PC_NEXT;
    logic       STK_nRW, STK_CE, STK_FULL, STK_EMPTY;
    logic       PC_LOAD, BUSY, DONE, OVERFLOW, UNDERFLOW;
    logic       force_full = 1'b0, force_empty = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    call_return_ctrl #(.ADDR_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET), .PC(PC), .TARGET(TARGET),
        .ERR_CLR(ERR_CLR), .STK_DATA_OUT(STK_DATA_OUT), .STK_nRW(STK_nRW),
        .STK_CE(STK_CE), .STK_DATA_IN(STK_DATA_IN), .STK_FULL(STK_FULL),
        .STK_EMPTY(STK_EMPTY), .PC_LOAD(PC_LOAD), .PC_NEXT(PC_NEXT), .BUSY(BUSY),
        .DONE(DONE), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    // Behavioural stack: writes on a push edge, read data valid after a pop edge.
    logic [7:0] mem [DEPTH];
    int         cnt = 0;
    logic [7:0] rd_q = '0;
    assign STK_DATA_IN = rd_q;
    assign STK_FULL    = (cnt == DEPTH) || force_full;
    assign STK_EMPTY   = (cnt == 0) || force_empty;

    always @(posedge CLK) begin
        if (STK_CE) begin
            if (STK_nRW) begin
                if (cnt < DEPTH) mem[cnt] <= STK_DATA_OUT;
                cnt <= cnt + 1;
            end else begin
                if (cnt > 0) rd_q <= mem[cnt-1];
                cnt <= cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic       rst, call, ret;
        logic [7:0] pc, tgt;
        logic       ff, fe, clr;
        logic       ce, nrw;
        logic [7:0] dout;
        logic       ld;
        logic [7:0] pcn;
        logic       busy, done, ovf, unf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input string n, input logic r, c, t, input logic [7:0] p, g,
                       input logic ff, fe, cl, ce, nrw, input logic [7:0] d,
                       input logic ld, input logic [7:0] pn, input logic b, dn, o, u);
        vec_t v;
        v = '{n, r, c, t, p, g, ff, fe, cl, ce, nrw, d, ld, pn, b, dn, o, u};
        vecs.push_back(v);
    endtask

    task automatic compare_row(input vec_t e);
        check({e.name, ".ce"},   STK_CE, e.ce);
        check({e.name, ".nrw"},  STK_nRW, e.nrw);
        check({e.name, ".dout"}, STK_DATA_OUT, e.dout);
        check({e.name, ".load"}, PC_LOAD, e.ld);
        check({e.name, ".pcn"},  PC_NEXT, e.pcn);
        check({e.name, ".busy"}, BUSY, e.busy);
        check({e.name, ".done"}, DONE, e.done);
        check({e.name, ".ovf"},  OVERFLOW, e.ovf);
        check({e.name, ".unf"},  UNDERFLOW, e.unf);
    endtask

    logic [7:0] pc_q[$];

    task automatic wait_load(input string name, input int want_lat);
        int lat = 1;
        logic [7:0] exp_pc;
        while (!PC_LOAD && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({name, ".latency"}, lat, want_lat);
        exp_pc = (pc_q.size() > 0) ? pc_q.pop_front() : 8'hXX;
        check({name, ".pc_next"}, PC_NEXT, exp_pc);
        check({name, ".done"}, DONE, 1'b1);
        @(posedge CLK); #1;
        check({name, ".idle"}, BUSY, 1'b0);
    endtask

    task automatic do_call(input string name, input logic [7:0] p, input logic [7:0] t);
        CALL = 1'b1; PC = p; TARGET = t;
        pc_q.push_back(t);
        @(posedge CLK); #1;
        CALL = 1'b0;
        check({name, ".ce"}, STK_CE, 1'b1);
        check({name, ".dout"}, STK_DATA_OUT, p + 8'd1);
        wait_load(name, 2);
    endtask

    task automatic do_ret(input string name, input logic [7:0] exp_addr);
        RET = 1'b1;
        pc_q.push_back(exp_addr);
        @(posedge CLK); #1;
        RET = 1'b0;
        check({name, ".ce"}, STK_CE, 1'b1);
        check({name, ".nrw"}, STK_nRW, 1'b0);
        wait_load(name, 3);
    endtask

    initial begin
        //   name      rst c r  pc     tgt   ff fe cl ce nrw dout  ld pcn   b  dn ovf     unf
        add("rst0",    1, 1, 0, 8'h10, 8'h40, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("rst1",    1, 1, 0, 8'h10, 8'h40, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("call_e0", 0, 1, 0, 8'h10, 8'h40, 0, 0, 0, 1, 1, 8'h11, 0, 8'h00, 1, 0, 0, 0);
        add("call_e1", 0, 1, 1, 8'h77, 8'h78, 0, 0, 0, 0, 1, 8'h11, 1, 8'h40, 1, 1, 0, 0);
        add("call_e2", 0, 0, 0, 8'h77, 8'h78, 0, 0, 0, 0, 1, 8'h11, 0, 8'h40, 0, 0, 0, 0);
        add("ret_e0",  0, 0, 1, 8'h77, 8'h78, 0, 0, 0, 1, 0, 8'h11, 0, 8'h40, 1, 0, 0, 0);
        add("ret_e1",  0, 1, 0, 8'h30, 8'h31, 0, 0, 0, 0, 0, 8'h11, 0, 8'h40, 1, 0, 0, 0);
        add("ret_e2",  0, 0, 0, 8'h30, 8'h31, 0, 0, 0, 0, 0, 8'h11, 1, 8'h11, 1, 1, 0, 0);
        add("ret_e3",  0, 0, 0, 8'h30, 8'h31, 0, 0, 0, 0, 0, 8'h11, 0, 8'h11, 0, 0, 0, 0);
        add("wrap_e0", 0, 1, 1, 8'hFF, 8'h80, 0, 0, 0, 1, 1, 8'h00, 0, 8'h11, 1, 0, 0, 0);
        add("wrap_e1", 0, 0, 0, 8'hFF, 8'h80, 0, 0, 0, 0, 1, 8'h00, 1, 8'h80, 1, 1, 0, 0);
        add("wrap_e2", 0, 0, 0, 8'hFF, 8'h80, 0, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 0);
        add("ovf_e0",  0, 1, 0, 8'h20, 8'h30, 1, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, 1, 0);
        add("ovf_e1",  0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, STICKY, 0);
        add("ovf_e2",  0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, STICKY, 0);
        add("ovf_clr", 0, 0, 0, 8'h20, 8'h30, 0, 0, 1, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 0);
        add("unf_e0",  0, 0, 1, 8'h20, 8'h30, 0, 1, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 1);
        add("unf_e1",  0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, STICKY);
        add("unf_win", 0, 0, 1, 8'h20, 8'h30, 0, 1, 1, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 1);
        add("unf_clr", 0, 0, 0, 8'h20, 8'h30, 0, 0, 1, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 0);
        add("unf_idl", 0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 1, 8'h00, 0, 8'h80, 0, 0, 0, 0);
        add("ret2_e0", 0, 0, 1, 8'h20, 8'h30, 0, 0, 0, 1, 0, 8'h00, 0, 8'h80, 1, 0, 0, 0);
        add("ret2_e1", 0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 0, 0, 0);
        add("ret2_e2", 0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 0, 0);
        add("ret2_e3", 0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("emp_e0",  0, 0, 1, 8'h20, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        add("emp_e1",  0, 0, 0, 8'h20, 8'h30, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, STICKY);
        add("emp_clr", 0, 0, 0, 8'h20, 8'h30, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("abrt_e0", 0, 1, 0, 8'h55, 8'h66, 0, 0, 0, 1, 1, 8'h56, 0, 8'h00, 1, 0, 0, 0);
        add("abrt_rs", 1, 0, 0, 8'h55, 8'h66, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("abrt_p1", 0, 0, 0, 8'h55, 8'h66, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add("abrt_p2", 0, 0, 0, 8'h55, 8'h66, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);

        #1;
        foreach (vecs[i]) begin
            RST = vecs[i].rst; CALL = vecs[i].call; RET = vecs[i].ret;
            PC = vecs[i].pc; TARGET = vecs[i].tgt;
            force_full = vecs[i].ff; force_empty = vecs[i].fe; ERR_CLR = vecs[i].clr;
            sb.push_back(vecs[i]);
            @(posedge CLK); #1;
            compare_row(sb.pop_front());
        end
        CALL = 1'b0; RET = 1'b0; RST = 1'b0; ERR_CLR = 1'b0;
        force_full = 1'b0; force_empty = 1'b0;

        // The aborted CALL still reached the stack (0x56); fill it to DEPTH.
        do_call("fill1", 8'h01, 8'h90);
        do_call("fill2", 8'h02, 8'hA0);
        do_call("fill3", 8'h03, 8'hB0);
        CALL = 1'b1; PC = 8'h04; TARGET = 8'hC0;
        @(posedge CLK); #1;
        CALL = 1'b0;
        check("full.ovf", OVERFLOW, 1'b1);
        check("full.ce", STK_CE, 1'b0);
        check("full.busy", BUSY, 1'b0);
        do_ret("pop_last", 8'h04);
        do_ret("pop_next", 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
